spi_flash_rd_seq: RTL and testbench
===================================

Name: spi_flash_rd_seq

Overview:
- Bus-master sequencer that drives the memory-mapped SPI peripheral's register port (CTRL 0x0, DATA 0x4, STATUS 0x8) to perform a complete serial-flash READ.
- Transaction: assert SS, send cmd 0x03, send 24-bit address MSB first, clock in len_i data bytes, deassert SS.
- Received bytes leave on a valid/ready byte stream.
- Sits beside the CPU on the SPI register port; it serves boot-load and DMA-style fetch.

Parameters:
- CLK_DIV, 8'd4, value written to CTRL[15:8].
- READ_CMD, 8'h03, first byte shifted out.
- TIMEOUT_CYC, 1023, maximum clk cycles per byte before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  start pulse/level; sampled only in IDLE
- addr_i  in  24  flash byte address; latched on accept
- len_i  in  16  number of data bytes; latched on accept
- cpol_i  in  1  CTRL[1] value; latched on accept
- cpha_i  in  1  CTRL[2] value; latched on accept
- busy_o  out  1  high from accept until return to IDLE
- done_o  out  1  one-cycle pulse at normal completion
- err_o  out  1  one-cycle pulse at timeout abort
- m_data_o  out  8  received byte
- m_valid_o  out  1  m_data_o valid
- m_ready_i  in  1  consumer accepts the byte
- spi_addr_o  out  32  register address to the SPI peripheral
- spi_wdata_o  out  32  register write data
- spi_wr_en_o  out  1  register write strobe
- spi_rdata_i  in  32  register read data (combinational from spi_addr_o)

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; byte counter 0.
- CTRL word:
  - Select: {16'h0, CLK_DIV, 4'h0, 1'b1, cpha, cpol, 1'b1}. SS is asserted and enable is set.
  - Deselect: {16'h0, CLK_DIV, 4'h0, 1'b0, cpha, cpol, 1'b0}.
- Byte stream: total = 4 + len bytes.
  - Index 0: READ_CMD.
  - Index 1–3: addr[23:16], addr[15:8], addr[7:0].
  - Index ≥4: 8'h00 dummy.
- State machine:
  - IDLE: req_i=1 latches inputs, sets busy_o and goes to LOAD.
  - LOAD: write DATA = {24'h0, byte}; one cycle with spi_wr_en_o=1 and spi_addr_o=0x4. Go to START.
  - START: write CTRL = select word; one cycle with strobe. Go to WAIT_HI.
  - WAIT_HI: spi_addr_o=0x8. Wait for STATUS[0]=1, then go to WAIT_LO. The peripheral's busy lags the start write by 2 cycles, so the block must not sample idle before it has seen busy.
  - WAIT_LO: wait for STATUS[0]=0, then go to CAPTURE.
  - CAPTURE: spi_addr_o=0x4; register spi_rdata_i[7:0].
    - Index <4: discard the byte and go to NEXT.
    - Otherwise: go to PUSH.
  - PUSH: m_valid_o=1 with m_data_o held stable until m_ready_i=1, then go to NEXT. The valid/ready handshake completes in the same cycle as m_ready_i.
  - NEXT: increment index. If index = 4+len, go to DESEL; else go to LOAD.
  - DESEL: write CTRL = deselect word. Go to IDLE with a one-cycle done_o pulse and busy_o cleared in the same cycle.
- spi_wr_en_o is 0 in every state except LOAD, START and DESEL. This keeps the peripheral's rx-byte writeback intact.
- len_i=0: only cmd and address are sent, with no stream output; done_o still pulses.
- req_i held high: a new transaction is accepted on the first IDLE cycle after done_o.
- While busy, req_i and all inputs are ignored.
- Backpressure: SPI activity is stalled while in PUSH; SS stays asserted.
- Index counter width: 17 bits, so 4+65535 fits without wrap.
- Reset mid-operation: returns to IDLE immediately with outputs 0. The peripheral is reset by the same rst_n.

Optional Feature:
- Macro: SPI_FLASH_RD_SEQ_TIMEOUT_EN
- With the macro: a cycle counter clears on entry to WAIT_HI. If it reaches TIMEOUT_CYC in WAIT_HI or WAIT_LO:
  - go to DESEL;
  - pulse err_o instead of done_o;
  - emit no further stream bytes.
- Without the macro: the block waits indefinitely and err_o is tied 0.

Decomposition:
- Package spi_flash_pkg contains:
  - state enum;
  - SPI register offsets (CTRL, DATA, STATUS);
  - CTRL bit positions (EN=0, CPOL=1, CPHA=2, SS=3, DIV=15:8);
  - HDR_BYTES=4.
- A single module; no sub-module is natural.

Test Plan:
- Basic read: addr=24'h012345, len=2, SPI slave model returns A5, 3C for the data bytes. MOSI must carry 03 01 23 45 00 00. Stream must output A5 then 3C, then done_o pulses once. SS ends high.
- Zero length: len=0. Exactly 4 bytes are shifted, no m_valid_o, and done_o pulses. Exactly 9 register writes occur: 4×(DATA, CTRL) plus DESEL.
- Backpressure: len=3, m_ready_i low for 50 cycles on byte 1. m_data_o must stay stable, no SPI strobe occurs during the stall, and the bytes arrive in order.
- Modes: cpol=1, cpha=1. Every select CTRL write equals 32'h0000_040F with CLK_DIV=4. The deselect write is 32'h0000_0406.
- Reset mid-byte: assert rst_n low during byte 2. All outputs go to 0 at once. A new req after release starts again from cmd 0x03.
- Timeout (macro on): the slave model holds STATUS[0]=1. err_o pulses after TIMEOUT_CYC cycles, a deselect CTRL write occurs, and done_o stays 0.

Source files
------------

// File: rtl/spi_flash_pkg.sv
//------------------------------------------------------------------------------
// Module   : spi_flash_pkg
// Contents : states, SPI register map and CTRL field helpers for spi_flash_rd_seq
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package spi_flash_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_START   = 4'd2,
    ST_WAIT_HI = 4'd3,
    ST_WAIT_LO = 4'd4,
    ST_CAPTURE = 4'd5,
    ST_PUSH    = 4'd6,
    ST_NEXT    = 4'd7,
    ST_DESEL   = 4'd8
  } state_t;

  localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
  localparam logic [31:0] REG_DATA   = 32'h0000_0004;
  localparam logic [31:0] REG_STATUS = 32'h0000_0008;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CPOL    = 1;
  localparam int CTRL_CPHA    = 2;
  localparam int CTRL_SS      = 3;
  localparam int CTRL_DIV_LSB = 8;
  localparam int CTRL_DIV_MSB = 15;

  localparam int HDR_BYTES = 4;

  // sel drives both SS and enable: a byte transfer always runs with SS asserted
  function automatic logic [31:0] ctrl_word(input logic [7:0] div, input logic cpha,
                                            input logic cpol, input logic sel);
    logic [31:0] w;
    w                           = '0;
    w[CTRL_EN]                  = sel;
    w[CTRL_CPOL]                = cpol;
    w[CTRL_CPHA]                = cpha;
    w[CTRL_SS]                  = sel;
    w[CTRL_DIV_MSB:CTRL_DIV_LSB] = div;
    return w;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [7:0] cmd, input logic [23:0] addr,
                                          input logic [16:0] idx);
    logic [7:0] b;
    case (idx)
      17'd0:   b = cmd;
      17'd1:   b = addr[23:16];
      17'd2:   b = addr[15:8];
      17'd3:   b = addr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_flash_rd_seq.sv
//------------------------------------------------------------------------------
// Module   : spi_flash_rd_seq
// Function : drives the SPI register port to run a serial-flash READ (0x03) and
//            streams the received data bytes out on a valid/ready interface.
//            Optional byte timeout: define SPI_FLASH_RD_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_flash_rd_seq
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] CLK_DIV     = 8'd4,
  parameter logic [7:0] READ_CMD    = 8'h03,
  parameter int         TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [23:0] addr_i,
  input  logic [15:0] len_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] spi_addr_o,
  output logic [31:0] spi_wdata_o,
  output logic        spi_wr_en_o,
  input  logic [31:0] spi_rdata_i
);

  state_t      r_state;
  logic [23:0] r_addr;
  logic [15:0] r_len;
  logic        r_cpol;
  logic        r_cpha;
  logic [16:0] r_idx;

  logic [16:0] w_idx_nxt;
  logic [16:0] w_total;
  logic [31:0] w_sel_word;
  logic [31:0] w_desel_word;

  assign w_idx_nxt    = r_idx + 17'd1;
  assign w_total      = 17'(HDR_BYTES) + {1'b0, r_len};
  assign w_sel_word   = ctrl_word(CLK_DIV, r_cpha, r_cpol, 1'b1);
  assign w_desel_word = ctrl_word(CLK_DIV, r_cpha, r_cpol, 1'b0);

`ifdef SPI_FLASH_RD_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] r_tmr;
  logic             r_abort;
  logic             w_tmo;
  assign w_tmo = (r_tmr == TMR_W'(TIMEOUT_CYC));
`else
  assign err_o = 1'b0;
`endif

  // Outputs are registered to describe the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_idx       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      m_data_o    <= '0;
      m_valid_o   <= 1'b0;
      spi_addr_o  <= '0;
      spi_wdata_o <= '0;
      spi_wr_en_o <= 1'b0;
`ifdef SPI_FLASH_RD_SEQ_TIMEOUT_EN
      err_o       <= 1'b0;
      r_tmr       <= '0;
      r_abort     <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
`ifdef SPI_FLASH_RD_SEQ_TIMEOUT_EN
      err_o  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_addr      <= addr_i;
            r_len       <= len_i;
            r_cpol      <= cpol_i;
            r_cpha      <= cpha_i;
            r_idx       <= '0;
            busy_o      <= 1'b1;
            r_state     <= ST_LOAD;
            spi_addr_o  <= REG_DATA;
            spi_wdata_o <= {24'h0, READ_CMD};
            spi_wr_en_o <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state     <= ST_START;
          spi_addr_o  <= REG_CTRL;
          spi_wdata_o <= w_sel_word;
          spi_wr_en_o <= 1'b1;
        end
        ST_START: begin
          r_state     <= ST_WAIT_HI;
          spi_addr_o  <= REG_STATUS;
          spi_wdata_o <= '0;
          spi_wr_en_o <= 1'b0;
`ifdef SPI_FLASH_RD_SEQ_TIMEOUT_EN
          r_tmr       <= '0;
`endif
        end
        // Peripheral busy lags the start write, so idle is only trusted after busy was seen
        ST_WAIT_HI: begin
`ifdef SPI_FLASH_RD_SEQ_TIMEOUT_EN
          r_tmr <= r_tmr + 1'b1;
          if (w_tmo) begin
            r_abort     <= 1'b1;
            r_state     <= ST_DESEL;
            spi_addr_o  <= REG_CTRL;
            spi_wdata_o <= w_desel_word;
            spi_wr_en_o <= 1'b1;
          end else
`endif
          if (spi_rdata_i[0]) begin
            r_state <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
`ifdef SPI_FLASH_RD_SEQ_TIMEOUT_EN
          r_tmr <= r_tmr + 1'b1;
          if (w_tmo) begin
            r_abort     <= 1'b1;
            r_state     <= ST_DESEL;
            spi_addr_o  <= REG_CTRL;
            spi_wdata_o <= w_desel_word;
            spi_wr_en_o <= 1'b1;
          end else
`endif
          if (!spi_rdata_i[0]) begin
            r_state    <= ST_CAPTURE;
            spi_addr_o <= REG_DATA;
          end
        end
        ST_CAPTURE: begin
          if (r_idx < 17'(HDR_BYTES)) begin
            r_state <= ST_NEXT;
          end else begin
            m_data_o  <= spi_rdata_i[7:0];
            m_valid_o <= 1'b1;
            r_state   <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            r_state   <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          r_idx       <= w_idx_nxt;
          spi_wr_en_o <= 1'b1;
          if (w_idx_nxt == w_total) begin
            r_state     <= ST_DESEL;
            spi_addr_o  <= REG_CTRL;
            spi_wdata_o <= w_desel_word;
          end else begin
            r_state     <= ST_LOAD;
            spi_addr_o  <= REG_DATA;
            spi_wdata_o <= {24'h0, hdr_byte(READ_CMD, r_addr, w_idx_nxt)};
          end
        end
        ST_DESEL: begin
          r_state     <= ST_IDLE;
          busy_o      <= 1'b0;
          spi_addr_o  <= '0;
          spi_wdata_o <= '0;
          spi_wr_en_o <= 1'b0;
`ifdef SPI_FLASH_RD_SEQ_TIMEOUT_EN
          err_o       <= r_abort;
          done_o      <= ~r_abort;
          r_abort     <= 1'b0;
`else
          done_o      <= 1'b1;
`endif
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_rd_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_spi_flash_rd_seq
// Function : self-checking bench for spi_flash_rd_seq with an SPI peripheral model
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_flash_rd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic [23:0] addr_i = '0;
  logic [15:0] len_i = '0;
  logic        cpol_i = 1'b0;
  logic        cpha_i = 1'b0;
  logic        busy_o, done_o, err_o, m_valid_o, spi_wr_en_o;
  logic [7:0]  m_data_o;
  logic        m_ready_i = 1'b1;
  logic [31:0] spi_addr_o, spi_wdata_o, spi_rdata_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_flash_rd_seq dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .len_i(len_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .spi_addr_o(spi_addr_o), .spi_wdata_o(spi_wdata_o), .spi_wr_en_o(spi_wr_en_o),
    .spi_rdata_i(spi_rdata_i)
  );

  // SPI peripheral model: busy rises 2 cycles after a select write, byte shifts in 10 cycles
  logic [31:0] p_ctrl;
  logic [7:0]  p_data;
  logic        p_busy;
  int          p_pend, p_cnt, wr_count;
  bit          stuck = 1'b0;
  logic [7:0]  miso_q[$], mosi_q[$], exp_q[$];
  logic [31:0] ctrl_log[$];

  assign spi_rdata_i = (spi_addr_o == 32'h0) ? p_ctrl :
                       (spi_addr_o == 32'h4) ? {24'h0, p_data} :
                       (spi_addr_o == 32'h8) ? {31'h0, p_busy} : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_ctrl <= '0; p_data <= '0; p_busy <= 1'b0; p_pend <= 0; p_cnt <= 0;
    end else begin
      if (spi_wr_en_o) wr_count <= wr_count + 1;
      if (spi_wr_en_o && spi_addr_o == 32'h0) begin
        p_ctrl <= spi_wdata_o;
        ctrl_log.push_back(spi_wdata_o);
        if (spi_wdata_o[3] && spi_wdata_o[0]) p_pend <= 2;
      end
      if (spi_wr_en_o && spi_addr_o == 32'h4) p_data <= spi_wdata_o[7:0];
      if (p_pend != 0) begin
        p_pend <= p_pend - 1;
        if (p_pend == 1) begin p_busy <= 1'b1; p_cnt <= 10; end
      end else if (p_busy && !stuck) begin
        if (p_cnt == 0) begin
          p_busy <= 1'b0;
          mosi_q.push_back(p_data);
          p_data <= (miso_q.size() > 0) ? miso_q.pop_front() : 8'hFF;
        end else p_cnt <= p_cnt - 1;
      end
    end
  end

  // Stream monitor / scoreboard and ready driver, evaluated between clock edges
  int done_cnt = 0, err_cnt = 0, rx_idx = 0, bp_left = 0;
  bit bp_en = 1'b0;
  initial begin : mon
    logic [7:0] e, held_d;
    bit held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done_o) done_cnt++;
        if (err_o) err_cnt++;
        if (bp_en && m_valid_o && rx_idx == 1 && bp_left > 0) begin
          m_ready_i = 1'b0; bp_left--;
        end else m_ready_i = 1'b1;
        if (m_valid_o) begin
          checks++;
          if (spi_wr_en_o !== 1'b0) begin
            failures++; $display("FAIL strobe_during_push got=%b want=0", spi_wr_en_o);
          end
          if (held_v) begin
            checks++;
            if (m_data_o !== held_d) begin
              failures++; $display("FAIL data_stable got=%h want=%h", m_data_o, held_d);
            end
          end
          if (m_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("FAIL stream_extra got=%h want=none", m_data_o);
            end else begin
              e = exp_q.pop_front();
              if (m_data_o !== e) begin
                failures++; $display("FAIL stream_data got=%h want=%h", m_data_o, e);
              end
            end
            rx_idx++; held_v = 1'b0;
          end else begin
            held_v = 1'b1; held_d = m_data_o;
          end
        end else held_v = 1'b0;
      end else begin
        held_v = 1'b0; m_ready_i = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    mosi_q.delete(); miso_q.delete(); exp_q.delete(); ctrl_log.delete();
    rx_idx = 0; bp_en = 1'b0;
  endtask

  task automatic start_txn(input logic [23:0] a, input logic [15:0] l, input logic pol, input logic pha);
    @(negedge clk);
    addr_i = a; len_i = l; cpol_i = pol; cpha_i = pha; req_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0; addr_i = 24'($urandom); len_i = 16'($urandom);
    cpol_i = 1'($urandom); cpha_i = 1'($urandom);
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL busy_on_accept got=%b want=1", busy_o); end
  endtask

  task automatic wait_end(input int budget, output int cycles);
    int d0, e0;
    bit seen;
    d0 = done_cnt; e0 = err_cnt; seen = 1'b0; cycles = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1; cycles++;
      if (done_cnt != d0 || err_cnt != e0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL end_of_txn got=timeout want=done_or_err"); end
    repeat (5) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    checks++;
    if ({busy_o, done_o, err_o, m_valid_o, spi_wr_en_o, m_data_o, spi_addr_o, spi_wdata_o} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b%b%b%b%b %h %h %h want=all_zero",
                           busy_o, done_o, err_o, m_valid_o, spi_wr_en_o, m_data_o, spi_addr_o, spi_wdata_o);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_mosi [6];
    int d0, cyc;
    exp_mosi = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00};
    do_reset();
    miso_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5, 8'h3C};
    exp_q  = '{8'hA5, 8'h3C};
    d0 = done_cnt;
    start_txn(24'h012345, 16'd2, 1'b0, 1'b0);
    wait_end(3000, cyc);
    checks++;
    if (mosi_q.size() != 6) begin failures++; $display("FAIL basic_mosi_count got=%0d want=6", mosi_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= mosi_q.size() || mosi_q[i] !== exp_mosi[i]) begin
        failures++; $display("FAIL basic_mosi[%0d] got=%h want=%h", i, (i < mosi_q.size()) ? mosi_q[i] : 8'hxx, exp_mosi[i]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL basic_stream_missing got=%0d left want=0", exp_q.size()); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt - d0); end
    checks++;
    if (ctrl_log.size() == 0 || ctrl_log[ctrl_log.size()-1] !== 32'h0000_0400) begin
      failures++; $display("FAIL basic_deselect got=%h want=00000400", (ctrl_log.size() > 0) ? ctrl_log[ctrl_log.size()-1] : 32'hx);
    end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b want=0", busy_o); end
  endtask

  task automatic test_zero_len();
    int d0, w0, r0, cyc;
    do_reset();
    d0 = done_cnt; w0 = wr_count; r0 = rx_idx;
    start_txn(24'hABCDEF, 16'd0, 1'b0, 1'b0);
    wait_end(2000, cyc);
    checks++;
    if (mosi_q.size() != 4) begin failures++; $display("FAIL zero_mosi_count got=%0d want=4", mosi_q.size()); end
    checks++;
    if (rx_idx != r0) begin failures++; $display("FAIL zero_stream got=%0d bytes want=0", rx_idx - r0); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL zero_done got=%0d want=1", done_cnt - d0); end
    checks++;
    if (wr_count - w0 != 9) begin failures++; $display("FAIL zero_writes got=%0d want=9", wr_count - w0); end
  endtask

  task automatic test_backpressure();
    int cyc;
    do_reset();
    miso_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33};
    exp_q  = '{8'h11, 8'h22, 8'h33};
    bp_left = 50; bp_en = 1'b1;
    start_txn(24'h000100, 16'd3, 1'b0, 1'b0);
    wait_end(5000, cyc);
    bp_en = 1'b0;
    checks++;
    if (bp_left != 0) begin failures++; $display("FAIL bp_stall_cycles got=%0d left want=0", bp_left); end
    checks++;
    if (exp_q.size() != 0 || rx_idx != 3) begin
      failures++; $display("FAIL bp_stream got=%0d bytes want=3", rx_idx);
    end
  endtask

  task automatic test_modes();
    int nsel, cyc;
    do_reset();
    miso_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h5A};
    exp_q  = '{8'h5A};
    start_txn(24'h7F0010, 16'd1, 1'b1, 1'b1);
    wait_end(3000, cyc);
    nsel = 0;
    foreach (ctrl_log[i]) begin
      if (ctrl_log[i][3]) begin
        nsel++;
        checks++;
        if (ctrl_log[i] !== 32'h0000_040F) begin
          failures++; $display("FAIL modes_select[%0d] got=%h want=0000040f", i, ctrl_log[i]);
        end
      end
    end
    checks++;
    if (nsel != 5) begin failures++; $display("FAIL modes_select_count got=%0d want=5", nsel); end
    checks++;
    if (ctrl_log.size() == 0 || ctrl_log[ctrl_log.size()-1] !== 32'h0000_0406) begin
      failures++; $display("FAIL modes_deselect got=%h want=00000406", (ctrl_log.size() > 0) ? ctrl_log[ctrl_log.size()-1] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    int n, cyc;
    do_reset();
    start_txn(24'h123456, 16'd4, 1'b0, 1'b0);
    n = 0;
    while (mosi_q.size() < 2 && n < 500) begin @(posedge clk); #1; n++; end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b want=1", busy_o); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, m_valid_o, spi_wr_en_o, m_data_o, spi_addr_o, spi_wdata_o} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs got=%b%b%b%b%b %h %h want=all_zero",
                           busy_o, done_o, err_o, m_valid_o, spi_wr_en_o, spi_addr_o, spi_wdata_o);
    end
    do_reset();
    miso_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h77};
    exp_q  = '{8'h77};
    start_txn(24'h000042, 16'd1, 1'b0, 1'b0);
    wait_end(3000, cyc);
    checks++;
    if (mosi_q.size() != 5 || mosi_q[0] !== 8'h03) begin
      failures++; $display("FAIL mid_restart got=%0d bytes first=%h want=5 bytes first=03",
                           mosi_q.size(), (mosi_q.size() > 0) ? mosi_q[0] : 8'hxx);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL mid_restart_stream got=%0d left want=0", exp_q.size()); end
  endtask

`ifdef SPI_FLASH_RD_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int d0, e0, cyc;
    do_reset();
    stuck = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    start_txn(24'h000000, 16'd1, 1'b0, 1'b0);
    wait_end(3000, cyc);
    checks++;
    if (err_cnt - e0 != 1) begin failures++; $display("FAIL tmo_err got=%0d want=1", err_cnt - e0); end
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL tmo_done got=%0d want=0", done_cnt - d0); end
    checks++;
    if (cyc < 1023) begin failures++; $display("FAIL tmo_latency got=%0d want>=1023", cyc); end
    checks++;
    if (ctrl_log.size() == 0 || ctrl_log[ctrl_log.size()-1] !== 32'h0000_0400) begin
      failures++; $display("FAIL tmo_deselect got=%h want=00000400", (ctrl_log.size() > 0) ? ctrl_log[ctrl_log.size()-1] : 32'hx);
    end
    stuck = 1'b0;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_modes();
    test_reset_mid();
`ifdef SPI_FLASH_RD_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=no_finish want=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
